// File: rtl/ctrl_tx.sv
// ctrl_tx: serial control-word transmitter for the 2-wire control link.
// Sends one {val, idx} frame per shadow bit that differs from ctrl_i.
module ctrl_tx #(
  parameter int DIV   = 4,
  parameter int IDX_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [2**IDX_W-1:0]  ctrl_i,
  input  logic                 force_i,
  output logic                 ctrl_clk_o,
  output logic                 ctrl_data_o,
  output logic                 busy_o,
  output logic [2**IDX_W-1:0]  shadow_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int NBIT = 2**IDX_W;
  localparam logic [7:0] PH_LAST = 8'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT_LO,
    S_BIT_HI,
    S_STOP_LO,
    S_STOP_HI,
    S_GAP
  } state_t;

  state_t            state_q;
  logic [7:0]        phase_q;
  logic [2:0]        bit_q;
  logic [IDX_W-1:0]  idx_q;
  logic              val_q;
  logic [NBIT-1:0]   force_mask_q;
  logic              force_pend_q;

  logic [NBIT-1:0]   dirty;
  logic [IDX_W-1:0]  low_idx;
  logic [IDX_W:0]    word;
  logic              ph_last;

  assign word    = {val_q, idx_q};
  assign ph_last = (phase_q == PH_LAST);

  // Dirty bits and the lowest dirty index (descending scan, lowest wins).
  always_comb begin
    dirty   = (ctrl_i ^ shadow_o) | force_mask_q | {NBIT{force_pend_q}};
    low_idx = '0;
    for (int i = NBIT - 1; i >= 0; i--) begin
      if (dirty[i]) low_idx = IDX_W'(i);
    end
  end

  // Frame sequencer; line levels are registered alongside the state.
  // Data moves one cycle into each LO phase so clk and data never
  // toggle together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      bit_q        <= '0;
      idx_q        <= '0;
      val_q        <= 1'b0;
      force_mask_q <= '0;
      force_pend_q <= 1'b0;
      ctrl_clk_o   <= 1'b1;
      ctrl_data_o  <= 1'b1;
      busy_o       <= 1'b0;
      shadow_o     <= '0;
      frame_cnt_o  <= '0;
    end else begin
      force_pend_q <= force_pend_q | force_i;
      if (ph_last) phase_q <= '0;
      else         phase_q <= phase_q + 8'd1;
      unique case (state_q)
        S_IDLE: begin
          phase_q      <= '0;
          force_mask_q <= force_mask_q | {NBIT{force_pend_q}};
          force_pend_q <= force_i;
          if (|dirty) begin
            idx_q       <= low_idx;
            val_q       <= ctrl_i[low_idx];
            state_q     <= S_START;
            busy_o      <= 1'b1;
            ctrl_data_o <= 1'b0;
          end
        end
        S_START: begin
          if (ph_last) begin
            state_q    <= S_BIT_LO;
            bit_q      <= '0;
            ctrl_clk_o <= 1'b0;
          end
        end
        S_BIT_LO: begin
          if (phase_q == '0) ctrl_data_o <= word[bit_q];
          if (ph_last) begin
            state_q    <= S_BIT_HI;
            ctrl_clk_o <= 1'b1;
          end
        end
        S_BIT_HI: begin
          if (ph_last) begin
            ctrl_clk_o <= 1'b0;
            if (bit_q == 3'd4) begin
              state_q <= S_STOP_LO;
            end else begin
              bit_q   <= bit_q + 3'd1;
              state_q <= S_BIT_LO;
            end
          end
        end
        S_STOP_LO: begin
          if (phase_q == '0) ctrl_data_o <= 1'b0;
          if (ph_last) begin
            state_q    <= S_STOP_HI;
            ctrl_clk_o <= 1'b1;
          end
        end
        S_STOP_HI: begin
          if (ph_last) begin
            shadow_o[idx_q]     <= val_q;
            force_mask_q[idx_q] <= 1'b0;
            frame_cnt_o         <= frame_cnt_o + 16'd1;
            state_q             <= S_GAP;
            ctrl_data_o         <= 1'b1;
          end
        end
        S_GAP: begin
          if (ph_last) begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_tx.sv
// tb_ctrl_tx: directed bench for ctrl_tx with a link decoder
// and protocol monitor on the clk/data lines.
module tb_ctrl_tx;

  localparam int DIV = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] ctrl_i = 16'h0000;
  logic        force_i = 1'b0;
  logic        ctrl_clk_o;
  logic        ctrl_data_o;
  logic        busy_o;
  logic [15:0] shadow_o;
  logic [15:0] frame_cnt_o;

  ctrl_tx #(.DIV(DIV), .IDX_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ctrl_i      (ctrl_i),
    .force_i     (force_i),
    .ctrl_clk_o  (ctrl_clk_o),
    .ctrl_data_o (ctrl_data_o),
    .busy_o      (busy_o),
    .shadow_o    (shadow_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  int cyc = 0;
  int edges = 0;
  int viol = 0;
  int nbits = 0;
  int start_cyc = 0;
  int last_len = 0;
  int busy_cnt = 0;
  bit in_frame = 1'b0;
  logic [4:0] cur = '0;
  logic pclk = 1'b1;
  logic pdat = 1'b1;
  logic [4:0] words[$];
  logic [15:0] shad_q[$];

  // Link decoder and protocol monitor, sampled 1 time unit after posedge.
  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (rst_i) begin
      in_frame = 1'b0;
      nbits = 0;
    end else begin
      if (busy_o) busy_cnt++;
      if (ctrl_clk_o !== pclk || ctrl_data_o !== pdat) edges++;
      if (ctrl_clk_o !== pclk && ctrl_data_o !== pdat) begin
        viol++;
      end else if (ctrl_data_o !== pdat && ctrl_clk_o && pclk) begin
        if (!ctrl_data_o) begin
          if (in_frame) viol++;
          in_frame = 1'b1;
          nbits = 0;
          start_cyc = cyc;
        end else begin
          if (!in_frame || nbits != 5) viol++;
          else begin
            words.push_back(cur);
            shad_q.push_back(shadow_o);
            last_len = cyc - start_cyc;
          end
          in_frame = 1'b0;
        end
      end else if (ctrl_clk_o && !pclk && in_frame && nbits < 5) begin
        cur[nbits] = ctrl_data_o;
        nbits++;
      end
    end
    pclk = ctrl_clk_o;
    pdat = ctrl_data_o;
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    words.delete();
    shad_q.delete();
    viol = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (words.size() >= n && !busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ctrl_i = 16'h0000;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({ctrl_clk_o, ctrl_data_o, busy_o} !== 3'b110)
      $display("FAIL rst_lines got %b exp 110",
               {ctrl_clk_o, ctrl_data_o, busy_o});
    else passed++;
    rst_i = 1'b0;
    edges = 0;
    busy_cnt = 0;
    repeat (100) @(negedge clk_i);
    checks++;
    if (edges !== 0) $display("FAIL idle_edges got %0d exp 0", edges);
    else passed++;
    checks++;
    if (busy_cnt !== 0) $display("FAIL idle_busy got %0d exp 0", busy_cnt);
    else passed++;
    checks++;
    if ({ctrl_clk_o, ctrl_data_o} !== 2'b11)
      $display("FAIL idle_lines got %b exp 11", {ctrl_clk_o, ctrl_data_o});
    else passed++;
    checks++;
    if (frame_cnt_o !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", frame_cnt_o);
    else passed++;
    checks++;
    if (shadow_o !== 16'h0000) $display("FAIL rst_shadow got %h exp 0000", shadow_o);
    else passed++;
  endtask

  task automatic test_single();
    bit ok;
    logic [4:0] w0;
    @(negedge clk_i);
    words.delete();
    shad_q.delete();
    busy_cnt = 0;
    viol = 0;
    ctrl_i = 16'h0020;
    wait_frames(1, 200, ok);
    repeat (70) @(negedge clk_i);
    checks++;
    if (!ok) $display("FAIL single_timeout got 0 exp 1");
    else passed++;
    checks++;
    if (words.size() !== 1) $display("FAIL single_nframes got %0d exp 1", words.size());
    else passed++;
    w0 = (words.size() > 0) ? words[0] : 5'bx;
    checks++;
    if (w0 !== 5'b10101) $display("FAIL single_word got %b exp 10101", w0);
    else passed++;
    checks++;
    if (shadow_o !== 16'h0020) $display("FAIL single_shadow got %h exp 0020", shadow_o);
    else passed++;
    checks++;
    if (frame_cnt_o !== 16'd1) $display("FAIL single_cnt got %0d exp 1", frame_cnt_o);
    else passed++;
    checks++;
    if (busy_cnt !== 14 * DIV) $display("FAIL single_busy got %0d exp %0d", busy_cnt, 14 * DIV);
    else passed++;
    // first START sample to first GAP sample spans 13 phases
    checks++;
    if (last_len !== 13 * DIV) $display("FAIL single_len got %0d exp %0d", last_len, 13 * DIV);
    else passed++;
    checks++;
    if (viol !== 0) $display("FAIL single_proto got %0d exp 0", viol);
    else passed++;
  endtask

  task automatic test_two();
    bit ok;
    logic [4:0] w0, w1;
    ctrl_i = 16'h0000;
    do_reset();
    ctrl_i = 16'h8001;
    wait_frames(2, 400, ok);
    repeat (70) @(negedge clk_i);
    checks++;
    if (!ok || words.size() !== 2)
      $display("FAIL two_nframes got %0d exp 2", words.size());
    else passed++;
    w0 = (words.size() > 0) ? words[0] : 5'bx;
    w1 = (words.size() > 1) ? words[1] : 5'bx;
    checks++;
    if (w0 !== 5'b10000) $display("FAIL two_word0 got %b exp 10000", w0);
    else passed++;
    checks++;
    if (w1 !== 5'b11111) $display("FAIL two_word1 got %b exp 11111", w1);
    else passed++;
    checks++;
    if (shadow_o !== 16'h8001) $display("FAIL two_shadow got %h exp 8001", shadow_o);
    else passed++;
    checks++;
    if (frame_cnt_o !== 16'd2) $display("FAIL two_cnt got %0d exp 2", frame_cnt_o);
    else passed++;
  endtask

  task automatic test_force();
    bit ok;
    logic [4:0] got, exp;
    words.delete();
    shad_q.delete();
    viol = 0;
    @(negedge clk_i);
    force_i = 1'b1;
    @(negedge clk_i);
    force_i = 1'b0;
    wait_frames(16, 1500, ok);
    repeat (70) @(negedge clk_i);
    checks++;
    if (!ok || words.size() !== 16)
      $display("FAIL force_nframes got %0d exp 16", words.size());
    else passed++;
    for (int i = 0; i < 16; i++) begin
      exp = {ctrl_i[i], 4'(i)};
      got = (words.size() > i) ? words[i] : 5'bx;
      checks++;
      if (got !== exp) $display("FAIL force_word%0d got %b exp %b", i, got, exp);
      else passed++;
    end
    checks++;
    if (shadow_o !== 16'h8001) $display("FAIL force_shadow got %h exp 8001", shadow_o);
    else passed++;
    checks++;
    if (frame_cnt_o !== 16'd18) $display("FAIL force_cnt got %0d exp 18", frame_cnt_o);
    else passed++;
    checks++;
    if (viol !== 0) $display("FAIL force_proto got %0d exp 0", viol);
    else passed++;
  endtask

  task automatic test_midframe();
    bit ok;
    bit hit;
    logic [4:0] w0, w1;
    logic [15:0] s0;
    ctrl_i = 16'h0000;
    do_reset();
    ctrl_i = 16'h0008;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (in_frame && nbits == 3) begin
        hit = 1'b1;
        break;
      end
    end
    ctrl_i = 16'h0000;
    checks++;
    if (!hit) $display("FAIL mid_reach got 0 exp 1");
    else passed++;
    wait_frames(2, 300, ok);
    repeat (70) @(negedge clk_i);
    checks++;
    if (!ok || words.size() !== 2)
      $display("FAIL mid_nframes got %0d exp 2", words.size());
    else passed++;
    w0 = (words.size() > 0) ? words[0] : 5'bx;
    w1 = (words.size() > 1) ? words[1] : 5'bx;
    s0 = (shad_q.size() > 0) ? shad_q[0] : 16'hxxxx;
    checks++;
    if (w0 !== 5'b10011) $display("FAIL mid_word0 got %b exp 10011", w0);
    else passed++;
    checks++;
    if (s0 !== 16'h0008) $display("FAIL mid_shadow0 got %h exp 0008", s0);
    else passed++;
    checks++;
    if (w1 !== 5'b00011) $display("FAIL mid_word1 got %b exp 00011", w1);
    else passed++;
    checks++;
    if (shadow_o !== 16'h0000) $display("FAIL mid_shadow got %h exp 0000", shadow_o);
    else passed++;
    checks++;
    if (viol !== 0) $display("FAIL mid_proto got %0d exp 0", viol);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    logic [4:0] w0, w1;
    ctrl_i = 16'h0000;
    do_reset();
    ctrl_i = 16'h0006;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (words.size() == 1 && in_frame && nbits == 2 && !ctrl_clk_o) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || shadow_o !== 16'h0002)
      $display("FAIL rmid_reach got %h exp 0002", shadow_o);
    else passed++;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({ctrl_clk_o, ctrl_data_o, busy_o} !== 3'b110)
      $display("FAIL rmid_lines got %b exp 110",
               {ctrl_clk_o, ctrl_data_o, busy_o});
    else passed++;
    checks++;
    if (shadow_o !== 16'h0000) $display("FAIL rmid_shadow got %h exp 0000", shadow_o);
    else passed++;
    checks++;
    if (frame_cnt_o !== 16'd0) $display("FAIL rmid_cnt got %0d exp 0", frame_cnt_o);
    else passed++;
    rst_i = 1'b0;
    words.delete();
    shad_q.delete();
    viol = 0;
    wait_frames(2, 300, ok);
    repeat (70) @(negedge clk_i);
    checks++;
    if (!ok || words.size() !== 2)
      $display("FAIL rmid_nframes got %0d exp 2", words.size());
    else passed++;
    w0 = (words.size() > 0) ? words[0] : 5'bx;
    w1 = (words.size() > 1) ? words[1] : 5'bx;
    checks++;
    if (w0 !== 5'b10001) $display("FAIL rmid_word0 got %b exp 10001", w0);
    else passed++;
    checks++;
    if (w1 !== 5'b10010) $display("FAIL rmid_word1 got %b exp 10010", w1);
    else passed++;
    checks++;
    if (shadow_o !== 16'h0006) $display("FAIL rmid_final got %h exp 0006", shadow_o);
    else passed++;
    checks++;
    if (viol !== 0) $display("FAIL rmid_proto got %0d exp 0", viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_force();
    test_midframe();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
